oam_dma: RTL and testbench
==========================

Name: oam_dma

Overview:
- Sprite DMA engine between the CPU bus and PPU sprite memory (OAM).
- On a CPU write to $4014, halts the CPU and copies 256 bytes from CPU page {data,8'h00} into OAM, starting at the PPU's current OAMADDR.
- Runs in the clock25 domain and advances only on ce_cpu ticks from the PPU.
- Feeds the OAM that the PPU sprite fetch reads through oama/oamd.

Parameters:
- DMA_REG, 16'h4014: CPU address that triggers a transfer.

Ports:
- clock25  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ce_cpu  in  1  CPU-cycle clock enable from PPU, one clock25 pulse per CPU cycle
- cpu_a  in  16  CPU address
- cpu_d  in  8  CPU write data
- cpu_w  in  1  CPU write strobe
- oam_start  in  8  current PPU OAMADDR
- dma_a  out  16  bus address while bus_own=1
- dma_i  in  8  bus read data, valid one ce_cpu period after dma_a
- bus_own  out  1  1 = DMA drives the bus address (bus mux select)
- rdy  out  1  0 = CPU halted
- oam_a  out  8  OAM write address
- oam_d  out  8  OAM write data
- oam_w  out  1  OAM write strobe, one clock25 wide
- busy  out  1  transfer in progress (state != IDLE)

Behaviour:
- Reset values (asynchronous, immediate, including mid-transfer): state=IDLE, rdy=1, bus_own=0, busy=0, oam_w=0, oam_a=0, oam_d=0, dma_a=0, page=0, idx=0, odd=0.
- A reset mid-transfer abandons the copy; OAM keeps whatever bytes were already written.
- odd: 1-bit flop, toggles on every ce_cpu.
- All state transitions happen only on clock25 edges with ce_cpu=1.
- The only exception is oam_w, which clears on the very next clock25 edge after it is set.
- IDLE:
  - Trigger when ce_cpu & cpu_w & cpu_a==DMA_REG.
  - On trigger: page<=cpu_d, idx<=0, base<=oam_start, rdy<=0, busy<=1, go HALT.
  - Writes to any other address are ignored.
- HALT:
  - One dummy cycle.
  - If odd==1 at this tick, go ALIGN; otherwise go READ.
  - The alignment check is subject to the optional feature.
- ALIGN: one extra dummy cycle, then go READ.
- READ:
  - bus_own=1, dma_a={page,idx}.
  - On the tick, go WRITE.
- WRITE:
  - bus_own=1, dma_a unchanged.
  - On the tick: oam_d<=dma_i, oam_a<=base+idx (mod 256), oam_w<=1, idx<=idx+1 (8-bit).
  - If idx==8'hFF, go IDLE with rdy<=1, bus_own<=0, busy<=0; otherwise go READ.
- bus_own is 1 exactly in READ and WRITE; it is 0 in HALT and ALIGN.
- rdy is low for exactly 513 ce_cpu ticks (even start) or 514 (odd start), counted from the trigger tick (exclusive) to the release tick (inclusive).
- Exactly 256 oam_w pulses per transfer. Source addresses {page,00} through {page,FF}, no carry into the page.
- OAM addresses wrap modulo 256 from base. base is latched at trigger; later oam_start changes are ignored.
- Writes to DMA_REG while busy are ignored. The CPU is halted, so this case occurs only in test.
- ce_cpu stuck low: state, idx and odd hold indefinitely, and outputs are stable.
- Back-to-back: a trigger on the same tick that returns to IDLE is not accepted. A trigger on the next ce_cpu tick is.

Optional Feature:
- Macro: OAM_DMA_ALIGN_EN.
- Defined: HALT goes to ALIGN when odd==1 (513/514-cycle behaviour matching hardware).
- Undefined: ALIGN state is not built, HALT always goes to READ, transfers are always 513 cycles, and odd may be removed.

Test Plan:
- Even start: RAM $0200..$02FF = index value, oam_start=0, write $02 to $4014 with odd=0 -> rdy low 513 ticks; OAM[i]=i for all i; 256 oam_w pulses.
- Odd start (macro defined): same stimulus with odd=1 at HALT -> rdy low 514 ticks. With the macro undefined -> 513 ticks.
- Wrap: oam_start=8'hF0, page $03 with RAM $0300+i = ~i -> first write oam_a=F0, d=FF; 17th write oam_a=00, d=EF; last write oam_a=EF, d=00.
- Address/ownership: capture dma_a on each READ -> sequence $0300..$03FF. bus_own=0 in HALT/ALIGN, 1 in READ/WRITE; oam_start changed to $55 mid-transfer -> no effect.
- Reset mid-op: assert reset_n=0 after 100 oam_w pulses -> immediately rdy=1, bus_own=0, busy=0, oam_w=0. After release, a write to $4015 -> no trigger; a write to $4014 -> fresh transfer starting at idx 0.
- Stall: hold ce_cpu=0 for 50 clock25 cycles mid-READ -> dma_a, state and idx unchanged; the transfer completes correctly after ce_cpu resumes.

Source files
------------

// File: rtl/oam_dma.sv
// ---------------------------------------------------------------------------
// oam_dma -- sprite DMA engine between the CPU bus and PPU sprite memory.
//
// A CPU write to DMA_REG halts the CPU (rdy=0) and copies the 256 bytes of
// CPU page {cpu_d,8'h00} into OAM, starting at the OAMADDR value sampled at
// the trigger and wrapping modulo 256. Every state change happens on a
// clock25 edge with ce_cpu=1; only the oam_w strobe clears on the very next
// clock25 edge so that each OAM write is exactly one clock25 wide.
//
// Optional feature macro: OAM_DMA_ALIGN_EN
//   defined   : HALT inserts one ALIGN cycle when the CPU-cycle parity flop
//               is odd (513 or 514 halted cycles).
//   undefined : no ALIGN state, no parity flop, always 513 halted cycles.
//
// Ports:
//   clock25   in   system clock
//   reset_n   in   asynchronous active-low reset
//   ce_cpu    in   CPU-cycle clock enable (one clock25 pulse per CPU cycle)
//   cpu_a     in   CPU address
//   cpu_d     in   CPU write data
//   cpu_w     in   CPU write strobe
//   oam_start in   current PPU OAMADDR
//   dma_a     out  bus address while bus_own=1
//   dma_i     in   bus read data, valid one ce_cpu period after dma_a
//   bus_own   out  DMA owns the bus address (READ/WRITE states)
//   rdy       out  0 = CPU halted
//   oam_a     out  OAM write address
//   oam_d     out  OAM write data
//   oam_w     out  OAM write strobe, one clock25 wide
//   busy      out  transfer in progress
// ---------------------------------------------------------------------------
module oam_dma #(
    parameter logic [15:0] DMA_REG = 16'h4014
) (
    input  logic        clock25,
    input  logic        reset_n,
    input  logic        ce_cpu,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_d,
    input  logic        cpu_w,
    input  logic [7:0]  oam_start,
    output logic [15:0] dma_a,
    input  logic [7:0]  dma_i,
    output logic        bus_own,
    output logic        rdy,
    output logic [7:0]  oam_a,
    output logic [7:0]  oam_d,
    output logic        oam_w,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
`ifdef OAM_DMA_ALIGN_EN
        S_ALIGN = 3'd2,
`endif
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  page_q,  page_d;
    logic [7:0]  idx_q,   idx_d;
    logic [7:0]  base_q,  base_d;
    logic [7:0]  oam_a_q, oam_a_d;
    logic [7:0]  oam_d_q, oam_d_d;
    logic        oam_w_q, oam_w_d;

`ifdef OAM_DMA_ALIGN_EN
    // CPU-cycle parity; decides whether HALT needs an extra alignment cycle.
    logic odd_q;

    always_ff @(posedge clock25 or negedge reset_n) begin
        if (!reset_n) begin
            odd_q <= 1'b0;
        end else if (ce_cpu) begin
            odd_q <= ~odd_q;
        end
    end
`endif

    always_ff @(posedge clock25 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
            base_q  <= 8'h00;
            oam_a_q <= 8'h00;
            oam_d_q <= 8'h00;
            oam_w_q <= 1'b0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            oam_a_q <= oam_a_d;
            oam_d_q <= oam_d_d;
            oam_w_q <= oam_w_d;
        end
    end

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        base_d  = base_q;
        oam_a_d = oam_a_q;
        oam_d_d = oam_d_q;
        // The strobe is not held: it drops on the edge after it rises.
        oam_w_d = 1'b0;

        if (ce_cpu) begin
            case (state_q)
                S_IDLE: begin
                    // Only accepted from IDLE, so the tick that ends a
                    // transfer can never start another one.
                    if (cpu_w && (cpu_a == DMA_REG)) begin
                        page_d  = cpu_d;
                        idx_d   = 8'h00;
                        base_d  = oam_start;
                        state_d = S_HALT;
                    end
                end
                S_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
                    state_d = odd_q ? S_ALIGN : S_READ;
`else
                    state_d = S_READ;
`endif
                end
`ifdef OAM_DMA_ALIGN_EN
                S_ALIGN: begin
                    state_d = S_READ;
                end
`endif
                S_READ: begin
                    state_d = S_WRITE;
                end
                S_WRITE: begin
                    oam_d_d = dma_i;
                    oam_a_d = base_q + idx_q;
                    oam_w_d = 1'b1;
                    idx_d   = idx_q + 8'h01;
                    state_d = (idx_q == 8'hFF) ? S_IDLE : S_READ;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Status outputs decode straight from the state register so that an
    // asynchronous reset releases the CPU and the bus immediately.
    assign busy    = (state_q != S_IDLE);
    assign rdy     = ~busy;
    assign bus_own = (state_q == S_READ) || (state_q == S_WRITE);
    // idx only advances on the WRITE tick, so the address is stable across
    // the READ/WRITE pair; the low byte never carries into the page.
    assign dma_a   = bus_own ? {page_q, idx_q} : 16'h0000;
    assign oam_a   = oam_a_q;
    assign oam_d   = oam_d_q;
    assign oam_w   = oam_w_q;

endmodule

// File: tb/tb_oam_dma.sv
module tb_oam_dma;

    logic        clock25   = 1'b0;
    logic        reset_n   = 1'b0;
    logic        ce_cpu    = 1'b0;
    logic [15:0] cpu_a     = 16'h0000;
    logic [7:0]  cpu_d     = 8'h00;
    logic        cpu_w     = 1'b0;
    logic [7:0]  oam_start = 8'h00;
    logic [7:0]  dma_i     = 8'h00;
    logic [15:0] dma_a;
    logic        bus_own;
    logic        rdy;
    logic [7:0]  oam_a;
    logic [7:0]  oam_d;
    logic        oam_w;
    logic        busy;

`ifdef OAM_DMA_ALIGN_EN
    localparam int ODD_TICKS = 514;
    localparam int ODD_NOWN  = 2;
`else
    localparam int ODD_TICKS = 513;
    localparam int ODD_NOWN  = 1;
`endif

    oam_dma dut (
        .clock25  (clock25),
        .reset_n  (reset_n),
        .ce_cpu   (ce_cpu),
        .cpu_a    (cpu_a),
        .cpu_d    (cpu_d),
        .cpu_w    (cpu_w),
        .oam_start(oam_start),
        .dma_a    (dma_a),
        .dma_i    (dma_i),
        .bus_own  (bus_own),
        .rdy      (rdy),
        .oam_a    (oam_a),
        .oam_d    (oam_d),
        .oam_w    (oam_w),
        .busy     (busy)
    );

    always #5 clock25 = ~clock25;

    int n_vec = 0;
    int n_bad = 0;
    bit ce_en = 1'b1;

    // ce_cpu: one clock25 pulse every third clock while enabled.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clock25);
            #1;
            cnt = (cnt == 2) ? 0 : cnt + 1;
            ce_cpu = ce_en && (cnt == 2);
        end
    end

    // CPU-cycle counter since reset; bit 0 is the parity the DUT sees.
    int tick_cnt;
    always @(posedge clock25 or negedge reset_n) begin
        if (!reset_n) tick_cnt <= 0;
        else if (ce_cpu) tick_cnt <= tick_cnt + 1;
    end

    // Bus memory: page $02 holds the index, page $03 its complement.
    function automatic logic [7:0] mem_read(input logic [15:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        case (a[15:8])
            8'h02:   mem_read = lo;
            8'h03:   mem_read = ~lo;
            default: mem_read = 8'hA5;
        endcase
    endfunction

    // Read data becomes valid one CPU cycle after the address is presented.
    initial begin
        logic [7:0] tmp;
        forever begin
            @(posedge clock25);
            if (ce_cpu && bus_own) begin
                tmp = mem_read(dma_a);
                #1 dma_i = tmp;
            end
        end
    end

    // Monitor, sampled on the falling edge.
    int         low_cnt = 0, own_cnt = 0, nown_cnt = 0;
    int         n_wr = 0, n_addr = 0;
    logic [7:0] wr_a [0:4095];
    logic [7:0] wr_d [0:4095];
    logic [15:0] addr_log [0:8191];

    always @(negedge clock25) begin
        if (reset_n) begin
            if (ce_cpu && !rdy) begin
                low_cnt++;
                if (bus_own) own_cnt++;
                else nown_cnt++;
            end
            if (ce_cpu && bus_own) begin
                if (n_addr < 8192) addr_log[n_addr] = dma_a;
                n_addr++;
            end
            if (oam_w) begin
                if (n_wr < 4096) begin
                    wr_a[n_wr] = oam_a;
                    wr_d[n_wr] = oam_d;
                end
                n_wr++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns at #2 inside a cycle whose closing edge is a ce_cpu tick.
    task automatic wait_tick_slot(input bit want_par, input bit use_par);
        int g;
        g = 0;
        forever begin
            @(posedge clock25);
            #2;
            if (ce_cpu && (!use_par || (tick_cnt[0] == want_par))) break;
            g++;
            if (g > 50) begin
                chk("ce_slot_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d,
                             input bit want_par, input bit use_par);
        wait_tick_slot(want_par, use_par);
        cpu_a = a;
        cpu_d = d;
        cpu_w = 1'b1;
        @(posedge clock25);
        #2;
        cpu_w = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int g;
        g = 0;
        while (busy && g < 5000) begin
            @(posedge clock25);
            #2;
            g++;
        end
        if (busy) chk(name, 32'd1, 32'd0);
    endtask

    typedef struct {
        logic [7:0] page;
        logic [7:0] start;
        bit         halt_odd;
        bit         chg55;
        bit         stall;
        bit         hold_w;
        int         exp_ticks;
        int         exp_nown;
        logic [7:0] fa, fd, sa, sd, la, ld;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] page, input logic [7:0] start,
                                input bit halt_odd, input bit chg55, input bit stall,
                                input bit hold_w, input int exp_ticks, input int exp_nown,
                                input logic [7:0] fa, input logic [7:0] fd,
                                input logic [7:0] sa, input logic [7:0] sd,
                                input logic [7:0] la, input logic [7:0] ld);
        vec_t v;
        v.page = page; v.start = start; v.halt_odd = halt_odd;
        v.chg55 = chg55; v.stall = stall; v.hold_w = hold_w;
        v.exp_ticks = exp_ticks; v.exp_nown = exp_nown;
        v.fa = fa; v.fd = fd; v.sa = sa; v.sd = sd; v.la = la; v.ld = ld;
        return v;
    endfunction

    task automatic run_vec(input int i, input vec_t v);
        int bw, ba, bl, bo, bn, g, bad_d, bad_a, sbad;
        bit stalled, timed_out;
        logic [15:0] snap;
        logic [7:0]  ea;
        logic [15:0] exa;
        int tc;

        oam_start = v.start;
        bw = n_wr; ba = n_addr; bl = low_cnt; bo = own_cnt; bn = nown_cnt;
        stalled = 1'b0;
        // The parity at HALT is the opposite of the parity at the trigger tick.
        cpu_write(16'h4014, v.page, ~v.halt_odd, 1'b1);
        chk($sformatf("v%0d_busy_after_trigger", i), {31'd0, busy}, 32'd1);
        if (v.hold_w) begin
            cpu_a = 16'h4014;
            cpu_d = 8'h03;
            cpu_w = 1'b1;
        end

        g = 0;
        timed_out = 1'b1;
        while (g < 5000) begin
            @(posedge clock25);
            #2;
            g++;
            if (v.chg55 && (n_wr - bw >= 50)) oam_start = 8'h55;
            if (v.stall && !stalled && oam_w && (n_wr - bw == 99)) begin
                // 100th write just issued, so the engine is now in READ.
                stalled = 1'b1;
                ce_en = 1'b0;
                snap = dma_a;
                chk($sformatf("v%0d_stall_dma_a", i), {16'd0, dma_a}, {16'd0, v.page, 8'd100});
                sbad = 0;
                repeat (50) begin
                    @(posedge clock25);
                    #2;
                    if (dma_a !== snap || bus_own !== 1'b1 || oam_w !== 1'b0 || busy !== 1'b1)
                        sbad++;
                end
                chk($sformatf("v%0d_stall_hold", i), sbad, 32'd0);
                ce_en = 1'b1;
            end
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
        end
        if (timed_out) chk($sformatf("v%0d_done_timeout", i), 32'd1, 32'd0);

        @(negedge clock25);
        #1;
        chk($sformatf("v%0d_rdy_release", i), {31'd0, rdy}, 32'd1);
        chk($sformatf("v%0d_rdy_low_ticks", i), low_cnt - bl, v.exp_ticks);
        chk($sformatf("v%0d_own_ticks", i), own_cnt - bo, 32'd512);
        chk($sformatf("v%0d_nown_ticks", i), nown_cnt - bn, v.exp_nown);
        chk($sformatf("v%0d_oam_w_pulses", i), n_wr - bw, 32'd256);
        chk($sformatf("v%0d_first_a", i), {24'd0, wr_a[bw]}, {24'd0, v.fa});
        chk($sformatf("v%0d_first_d", i), {24'd0, wr_d[bw]}, {24'd0, v.fd});
        chk($sformatf("v%0d_17th_a", i), {24'd0, wr_a[bw + 16]}, {24'd0, v.sa});
        chk($sformatf("v%0d_17th_d", i), {24'd0, wr_d[bw + 16]}, {24'd0, v.sd});
        chk($sformatf("v%0d_last_a", i), {24'd0, wr_a[bw + 255]}, {24'd0, v.la});
        chk($sformatf("v%0d_last_d", i), {24'd0, wr_d[bw + 255]}, {24'd0, v.ld});

        bad_d = 0;
        for (int k = 0; k < 256; k++) begin
            ea = v.start + k[7:0];
            if (wr_a[bw + k] !== ea || wr_d[bw + k] !== mem_read({v.page, k[7:0]})) bad_d++;
        end
        chk($sformatf("v%0d_oam_contents", i), bad_d, 32'd0);

        bad_a = 0;
        for (int k = 0; k < 512; k++) begin
            exa = {v.page, k[8:1]};
            if (addr_log[ba + k] !== exa) bad_a++;
        end
        chk($sformatf("v%0d_dma_a_seq", i), bad_a, 32'd0);

        if (v.hold_w) begin
            // cpu_w was held through the release tick; the next tick re-triggers.
            tc = tick_cnt;
            g = 0;
            while (tick_cnt == tc && g < 20) begin
                @(posedge clock25);
                #2;
                g++;
            end
            chk($sformatf("v%0d_retrigger_next_tick", i), {31'd0, busy}, 32'd1);
            cpu_w = 1'b0;
            wait_idle($sformatf("v%0d_retrigger_timeout", i));
        end
        $display("vector %0d: page %02h start %02h halt_odd %0d -> %0d halted ticks, %0d writes",
                 i, v.page, v.start, v.halt_odd, low_cnt - bl, n_wr - bw);
    endtask

    initial begin
        vec_t vec [0:5];
        int bw, g;

        vec[0] = mk(8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 513, 1,
                    8'h00, 8'h00, 8'h10, 8'h10, 8'hFF, 8'hFF);
        vec[1] = mk(8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, ODD_TICKS, ODD_NOWN,
                    8'h00, 8'h00, 8'h10, 8'h10, 8'hFF, 8'hFF);
        vec[2] = mk(8'h03, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 513, 1,
                    8'hF0, 8'hFF, 8'h00, 8'hEF, 8'hEF, 8'h00);
        vec[3] = mk(8'h03, 8'h10, 1'b1, 1'b0, 1'b1, 1'b0, ODD_TICKS, ODD_NOWN,
                    8'h10, 8'hFF, 8'h20, 8'hEF, 8'h0F, 8'h00);
        vec[4] = mk(8'h02, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 513, 1,
                    8'h80, 8'h00, 8'h90, 8'h10, 8'h7F, 8'hFF);
        vec[5] = mk(8'h03, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, ODD_TICKS, ODD_NOWN,
                    8'h00, 8'hFF, 8'h10, 8'hEF, 8'hFF, 8'h00);

        repeat (4) @(posedge clock25);
        #2;
        chk("reset_rdy",     {31'd0, rdy},     32'd1);
        chk("reset_busy",    {31'd0, busy},    32'd0);
        chk("reset_bus_own", {31'd0, bus_own}, 32'd0);
        chk("reset_oam_w",   {31'd0, oam_w},   32'd0);
        chk("reset_oam_a_d", {16'd0, oam_a, oam_d}, 32'd0);
        chk("reset_dma_a",   {16'd0, dma_a},   32'd0);
        reset_n = 1'b1;
        repeat (3) @(posedge clock25);

        for (int i = 0; i < 5; i++) run_vec(i, vec[i]);

        // Reset in the middle of a transfer, right as the 100th write strobes.
        oam_start = 8'h00;
        bw = n_wr;
        cpu_write(16'h4014, 8'h02, 1'b0, 1'b0);
        g = 0;
        while (!(oam_w && (n_wr - bw == 99)) && g < 5000) begin
            @(posedge clock25);
            #2;
            g++;
        end
        chk("midreset_reached_100", {31'd0, oam_w}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midreset_rdy",     {31'd0, rdy},     32'd1);
        chk("midreset_busy",    {31'd0, busy},    32'd0);
        chk("midreset_bus_own", {31'd0, bus_own}, 32'd0);
        chk("midreset_oam_w",   {31'd0, oam_w},   32'd0);
        chk("midreset_oam_a_d", {16'd0, oam_a, oam_d}, 32'd0);
        $display("mid-transfer reset after %0d writes", n_wr - bw);
        repeat (3) @(posedge clock25);
        #2;
        reset_n = 1'b1;

        cpu_write(16'h4015, 8'h02, 1'b0, 1'b0);
        repeat (10) @(posedge clock25);
        #2;
        chk("wrong_addr_no_trigger", {31'd0, busy}, 32'd0);
        $display("write to 4015: busy=%0d", busy);

        run_vec(5, vec[5]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
